// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl
//   Ramps the duty step of an external PWM generator toward a requested
//   target. One increase_duty/decrease_duty pulse is issued per step and
//   consecutive pulses are separated by GAP idle cycles. The tracked duty is
//   always within 0..DUTY_MAX.
//
// Parameters
//   DUTY_MAX  highest duty step (10 = 100%)
//   GAP       idle cycles between consecutive step pulses (>= 1)
//   DW        width of the duty fields, DUTY_MAX < 2**DW
//
// Ports
//   clk            single clock, rising edge
//   rst_n          asynchronous active-low reset
//   tgt_valid      new target duty offered
//   tgt_duty       requested duty step (values above DUTY_MAX are clamped)
//   tgt_ready      target accepted on an edge with tgt_valid && tgt_ready
//   increase_duty  one-cycle step-up pulse
//   decrease_duty  one-cycle step-down pulse
//   duty           tracked duty step
//   busy           high whenever the FSM is not in IDLE
//   done           one-cycle pulse when duty reaches the target
//
// Build option
//   PWM_RAMP_ABORT_EN  when defined, targets are accepted in every state. A
//                      new target replaces the old one mid-ramp. A pulse that
//                      is already out still updates duty, and the direction
//                      is re-evaluated at the next STEP.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a target, tgt_ready high
// STEP  | one pulse cycle; duty moves by one on the edge leaving STEP
// WAIT  | GAP idle cycles between pulses
// DONE  | duty equals target, done high for this single cycle

module pwm_ramp_ctrl #(
  parameter int DUTY_MAX = 10,
  parameter int GAP      = 8,
  parameter int DW       = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tgt_valid,
  input  logic [DW-1:0] tgt_duty,
  output logic          tgt_ready,
  output logic          increase_duty,
  output logic          decrease_duty,
  output logic [DW-1:0] duty,
  output logic          busy,
  output logic          done
);

`ifdef PWM_RAMP_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  localparam int            CW   = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [DW-1:0] DMAX = DW'(DUTY_MAX);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP - 1);

  typedef enum logic [1:0] {IDLE, STEP, WAIT, DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] duty_q, duty_d;
  logic [DW-1:0] target_q, target_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          inc_q, inc_d;
  logic          dec_q, dec_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          ready_q, ready_d;

  logic          accept;
  logic [DW-1:0] tgt_clamped;

  assign accept      = tgt_valid && ready_q;
  assign tgt_clamped = (tgt_duty > DMAX) ? DMAX : tgt_duty;

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    cnt_d    = cnt_q;

    // The pulse registers are only high during STEP, so the duty update
    // follows the pulse actually issued even if the target changes under it.
    if (inc_q && (duty_q < DMAX)) begin
      duty_d = duty_q + DW'(1);
    end else if (dec_q && (duty_q != '0)) begin
      duty_d = duty_q - DW'(1);
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          target_d = tgt_clamped;
          state_d  = (tgt_clamped == duty_q) ? DONE : STEP;
        end
      end
      STEP: begin
        if (ABORT_EN && accept) begin
          target_d = tgt_clamped;
        end
        if (duty_d == target_d) begin
          state_d = DONE;
        end else begin
          state_d = WAIT;
          cnt_d   = GAP_LOAD;
        end
      end
      WAIT: begin
        if (ABORT_EN && accept) begin
          target_d = tgt_clamped;
        end
        if (target_d == duty_q) begin
          state_d = DONE;
        end else if (cnt_q == '0) begin
          state_d = STEP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (ABORT_EN && accept) begin
          target_d = tgt_clamped;
          state_d  = (tgt_clamped == duty_q) ? DONE : STEP;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are derived from the next state so they register in step
    // with it.
    inc_d   = (state_d == STEP) && (target_d > duty_d);
    dec_d   = (state_d == STEP) && (target_d < duty_d);
    done_d  = (state_d == DONE);
    busy_d  = (state_d != IDLE);
    ready_d = ABORT_EN || (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      duty_q   <= '0;
      target_q <= '0;
      cnt_q    <= '0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  assign tgt_ready     = ready_q;
  assign increase_duty = inc_q;
  assign decrease_duty = dec_q;
  assign duty          = duty_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
